// File: rtl/addsub_pipe_p.sv
// Pipelined two's-complement add/subtract: operands are prepared and registered at accept,
// then one CHUNK-bit slice is resolved per stage with the carry rippling stage to stage.
module addsub_pipe_p #(
  parameter int SIZE  = 32,
  parameter int CHUNK = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            IN_VALID,
  output logic            IN_READY,
  input  logic [SIZE-1:0] A,
  input  logic [SIZE-1:0] B,
  input  logic            CIN,
  input  logic [1:0]      OP,
  output logic            OUT_VALID,
  input  logic            OUT_READY,
  output logic [SIZE-1:0] SUM,
  output logic            COUT,
  output logic            ZERO_FLAG,
  output logic            OVERFLOW_FLAG,
  output logic            NEG_FLAG
);

  localparam int STAGES = SIZE / CHUNK;
  localparam int LAST   = STAGES - 1;

  logic            adv;
  logic [SIZE-1:0] x_d;
  logic [SIZE-1:0] y_d;
  logic            c0_d;

  // Level k holds the operand set about to have slice k resolved; level STAGES is the output.
  logic [SIZE-1:0] x_q [0:STAGES-1];
  logic [SIZE-1:0] y_q [0:STAGES-1];
  logic            c_q [0:STAGES];
  logic            v_q [0:STAGES];
  logic            z_q [0:STAGES];
  logic [SIZE-1:0] s_q [1:STAGES];
  logic            ovf_q;

  logic [CHUNK:0]  slice_sum [0:STAGES-1];
  logic [SIZE-1:0] s_d       [0:STAGES-1];

  // Every register shifts together, so a full pipe simply freezes under back-pressure.
  assign adv      = !v_q[STAGES] || OUT_READY;
  assign IN_READY = adv;

  // Subtraction is folded into an add of the inverted operand plus carry-in.
  always_comb begin
    x_d  = A;
    y_d  = B;
    c0_d = 1'b0;
    case (OP)
      2'b01: begin
        y_d  = ~B;
        c0_d = 1'b1;
      end
      2'b10: begin
        y_d  = ~B;
        c0_d = CIN;
      end
      2'b11: begin
        x_d  = B;
        y_d  = ~A;
        c0_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q[0] <= 1'b0;
      x_q[0] <= '0;
      y_q[0] <= '0;
      c_q[0] <= 1'b0;
      z_q[0] <= 1'b0;
    end else if (adv) begin
      v_q[0] <= IN_VALID;
      if (IN_VALID) begin
        x_q[0] <= x_d;
        y_q[0] <= y_d;
        c_q[0] <= c0_d;
        z_q[0] <= 1'b1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      assign slice_sum[gi] = {1'b0, x_q[gi][gi*CHUNK +: CHUNK]}
                           + {1'b0, y_q[gi][gi*CHUNK +: CHUNK]}
                           + {{CHUNK{1'b0}}, c_q[gi]};

      if (gi == 0) begin : g_first
        assign s_d[gi] = SIZE'(slice_sum[gi][CHUNK-1:0]);
      end else begin : g_merge
        assign s_d[gi] = (s_q[gi] & ~(SIZE'({CHUNK{1'b1}}) << (gi*CHUNK)))
                       | (SIZE'(slice_sum[gi][CHUNK-1:0]) << (gi*CHUNK));
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v_q[gi+1] <= 1'b0;
          c_q[gi+1] <= 1'b0;
          z_q[gi+1] <= 1'b0;
          s_q[gi+1] <= '0;
        end else if (adv) begin
          v_q[gi+1] <= v_q[gi];
          c_q[gi+1] <= slice_sum[gi][CHUNK];
          z_q[gi+1] <= z_q[gi] && (slice_sum[gi][CHUNK-1:0] == '0);
          s_q[gi+1] <= s_d[gi];
        end
      end

      if (gi < LAST) begin : g_fwd
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            x_q[gi+1] <= '0;
            y_q[gi+1] <= '0;
          end else if (adv) begin
            x_q[gi+1] <= x_q[gi];
            y_q[gi+1] <= y_q[gi];
          end
        end
      end
    end
  endgenerate

  // Carry into the MSB is recovered from the MSB sum bit and the two operand MSBs.
  logic msb_cin;
  assign msb_cin = slice_sum[LAST][CHUNK-1] ^ x_q[LAST][SIZE-1] ^ y_q[LAST][SIZE-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (adv) begin
      ovf_q <= slice_sum[LAST][CHUNK] ^ msb_cin;
    end
  end

  assign OUT_VALID     = v_q[STAGES];
  assign SUM           = s_q[STAGES];
  assign COUT          = c_q[STAGES];
  assign ZERO_FLAG     = z_q[STAGES];
  assign OVERFLOW_FLAG = ovf_q;
  assign NEG_FLAG      = s_q[STAGES][SIZE-1];

endmodule

// File: tb/tb_addsub_pipe_p.sv
// Bench for addsub_pipe_p: a 32/8 instance and a 16/16 (single-stage) instance share stimulus,
// each scored against an integer-arithmetic reference model in acceptance order.
module tb_addsub_pipe_p;

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
    logic        neg;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, out_ready, cin;
  logic [1:0]  op;
  logic [31:0] a, b;

  logic        in_ready0, out_valid0, cout0, zero0, ovf0, neg0;
  logic [31:0] sum0;
  logic        in_ready1, out_valid1, cout1, zero1, ovf1, neg1;
  logic [15:0] sum1;

  int   errors, checks;
  exp_t q0[$], q1[$];
  exp_t snap0, snap1;
  bit   stall0, stall1;

  logic [1:0]  rop [10];
  logic [31:0] ra [10], rb [10];
  logic        rc [10];

  always #5 clk = ~clk;

  addsub_pipe_p #(.SIZE(32), .CHUNK(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .IN_VALID(in_valid), .IN_READY(in_ready0),
    .A(a), .B(b), .CIN(cin), .OP(op), .OUT_VALID(out_valid0), .OUT_READY(out_ready),
    .SUM(sum0), .COUT(cout0), .ZERO_FLAG(zero0), .OVERFLOW_FLAG(ovf0), .NEG_FLAG(neg0)
  );

  addsub_pipe_p #(.SIZE(16), .CHUNK(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .IN_VALID(in_valid), .IN_READY(in_ready1),
    .A(a[15:0]), .B(b[15:0]), .CIN(cin), .OP(op), .OUT_VALID(out_valid1), .OUT_READY(out_ready),
    .SUM(sum1), .COUT(cout1), .ZERO_FLAG(zero1), .OVERFLOW_FLAG(ovf1), .NEG_FLAG(neg1)
  );

  // Reference: exact integer arithmetic; carry = unsigned result in range, overflow = signed result out of range.
  function automatic exp_t model(input int size, input logic [1:0] o, input logic [31:0] ai,
                                 input logic [31:0] bi, input logic ci);
    longint m, av, bv, sa, sb, u, s;
    exp_t r;
    m  = longint'(1) << size;
    av = longint'(ai) & (m - 1);
    bv = longint'(bi) & (m - 1);
    sa = (av >= m / 2) ? av - m : av;
    sb = (bv >= m / 2) ? bv - m : bv;
    case (o)
      2'd0:    begin u = av + bv;                    s = sa + sb;                    end
      2'd1:    begin u = av - bv;                    s = sa - sb;                    end
      2'd2:    begin u = av - bv - 1 + longint'(ci); s = sa - sb - 1 + longint'(ci); end
      default: begin u = bv - av;                    s = sb - sa;                    end
    endcase
    r.cout = (o == 2'd0) ? (u >= m) : (u >= 0);
    r.sum  = 32'(u & (m - 1));
    r.ovf  = (s >= m / 2) || (s < -(m / 2));
    r.zero = (r.sum == 32'd0);
    r.neg  = r.sum[size-1];
    return r;
  endfunction

  function automatic exp_t got0();
    return {sum0, cout0, ovf0, zero0, neg0};
  endfunction

  function automatic exp_t got1();
    return {16'h0, sum1, cout1, ovf1, zero1, neg1};
  endfunction

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 4))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000 | 32'($urandom_range(0, 3));
      default: return $urandom;
    endcase
  endfunction

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, want);
    end
  endtask

  task automatic cmp_res(input string tag, input exp_t g, input exp_t e);
    chk32({tag, ".sum"}, g.sum, e.sum);
    chk1({tag, ".cout"}, g.cout, e.cout);
    chk1({tag, ".ovf"}, g.ovf, e.ovf);
    chk1({tag, ".zero"}, g.zero, e.zero);
    chk1({tag, ".neg"}, g.neg, e.neg);
  endtask

  task automatic drive(input logic v, input logic [1:0] o, input logic [31:0] aa,
                       input logic [31:0] bb, input logic c);
    in_valid = v;
    op       = o;
    a        = aa;
    b        = bb;
    cin      = c;
  endtask

  // One clock cycle: entered 1 time unit after a rising edge with inputs already driven.
  task automatic tick(output bit acc0);
    exp_t e;
    #1;
    chk1("in_ready0", in_ready0, !out_valid0 || out_ready);
    chk1("in_ready1", in_ready1, !out_valid1 || out_ready);
    if (out_valid0 && out_ready) begin
      if (q0.size() == 0) chk1("spurious0", out_valid0, 1'b0);
      else begin
        e = q0.pop_front();
        $display("[%0t] dut0 out sum=%h cout=%b ovf=%b zero=%b neg=%b", $time, sum0, cout0, ovf0, zero0, neg0);
        cmp_res("dut0", got0(), e);
      end
    end
    if (out_valid1 && out_ready) begin
      if (q1.size() == 0) chk1("spurious1", out_valid1, 1'b0);
      else begin
        e = q1.pop_front();
        $display("[%0t] dut1 out sum=%h cout=%b ovf=%b zero=%b neg=%b", $time, sum1, cout1, ovf1, zero1, neg1);
        cmp_res("dut1", got1(), e);
      end
    end
    if (out_valid0 && !out_ready) begin
      if (stall0) cmp_res("hold0", got0(), snap0);
      snap0  = got0();
      stall0 = 1'b1;
    end else stall0 = 1'b0;
    if (out_valid1 && !out_ready) begin
      if (stall1) cmp_res("hold1", got1(), snap1);
      snap1  = got1();
      stall1 = 1'b1;
    end else stall1 = 1'b0;
    acc0 = in_valid && in_ready0;
    if (acc0) q0.push_back(model(32, op, a, b, cin));
    if (in_valid && in_ready1) q1.push_back(model(16, op, a, b, cin));
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk1({tag, ".ov0"}, out_valid0, 1'b0);
    chk32({tag, ".sum0"}, sum0, 32'h0);
    chk1({tag, ".flags0"}, cout0 | zero0 | ovf0 | neg0, 1'b0);
    chk1({tag, ".ov1"}, out_valid1, 1'b0);
    chk32({tag, ".sum1"}, {16'h0, sum1}, 32'h0);
    chk1({tag, ".flags1"}, cout1 | zero1 | ovf1 | neg1, 1'b0);
  endtask

  // Single op into an empty pipe; measures edges from accept to OUT_VALID on both instances.
  task automatic single(input logic [1:0] o, input logic [31:0] aa, input logic [31:0] bb, input logic c);
    bit acc;
    int lat0, lat1;
    out_ready = 1'b1;
    drive(1'b1, o, aa, bb, c);
    tick(acc);
    chk1("single.accept", acc, 1'b1);
    drive(1'b0, 2'd0, 32'h0, 32'h0, 1'b0);
    lat0 = -1;
    lat1 = -1;
    for (int i = 1; i <= 8; i++) begin
      tick(acc);
      if (out_valid0 && lat0 < 0) lat0 = i;
      if (out_valid1 && lat1 < 0) lat1 = i;
    end
    chk32("latency0", 32'(lat0), 32'd4);
    chk32("latency1", 32'(lat1), 32'd1);
    chk32("drain0", 32'(q0.size()), 32'd0);
    chk32("drain1", 32'(q1.size()), 32'd0);
  endtask

  initial begin
    bit acc;
    int sent;
    bit saw_low;
    errors    = 0;
    checks    = 0;
    stall0    = 1'b0;
    stall1    = 1'b0;
    rst_n     = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 2'd0, 32'h0, 32'h0, 1'b0);
    #1;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk1("ready_after_reset0", in_ready0, 1'b1);
    chk1("ready_after_reset1", in_ready1, 1'b1);

    // Directed cases: slice-boundary carry, full ripple, zero, reverse subtract, borrow chain.
    single(2'b00, 32'h0000_00FF, 32'h0000_0001, 1'b0);
    single(2'b01, 32'h8000_0000, 32'h0000_0001, 1'b0);
    single(2'b01, 32'h1234_5678, 32'h1234_5678, 1'b0);
    single(2'b11, 32'h0000_0005, 32'h0000_0003, 1'b0);
    single(2'b10, 32'h0000_0000, 32'h0000_0000, 1'b0);
    single(2'b10, 32'h0000_0000, 32'h0000_0000, 1'b1);
    single(2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1);

    // Back-pressure: 10 random ops, OUT_READY low for 6 cycles.
    for (int i = 0; i < 10; i++) begin
      rop[i] = 2'($urandom_range(0, 3));
      ra[i]  = rnd32();
      rb[i]  = rnd32();
      rc[i]  = 1'($urandom_range(0, 1));
    end
    sent    = 0;
    saw_low = 1'b0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      out_ready = !(cyc >= 3 && cyc < 9);
      if (sent < 10) drive(1'b1, rop[sent], ra[sent], rb[sent], rc[sent]);
      else drive(1'b0, 2'd0, 32'h0, 32'h0, 1'b0);
      tick(acc);
      if (acc) sent++;
      if (!in_ready0) saw_low = 1'b1;
      if (sent == 10 && q0.size() == 0 && q1.size() == 0) break;
    end
    chk32("stream.sent", 32'(sent), 32'd10);
    chk1("stream.ready_dropped", saw_low, 1'b1);
    chk32("stream.drain0", 32'(q0.size()), 32'd0);
    chk32("stream.drain1", 32'(q1.size()), 32'd0);

    // Random valid/ready mix.
    for (int cyc = 0; cyc < 80; cyc++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (cyc < 60) drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), rnd32(), rnd32(), 1'($urandom_range(0, 1)));
      else drive(1'b0, 2'd0, 32'h0, 32'h0, 1'b0);
      tick(acc);
    end
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) tick(acc);
    chk32("random.drain0", 32'(q0.size()), 32'd0);
    chk32("random.drain1", 32'(q1.size()), 32'd0);

    // Reset with three ops in flight.
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'($urandom_range(0, 3)), rnd32(), rnd32(), 1'($urandom_range(0, 1)));
      tick(acc);
    end
    drive(1'b0, 2'd0, 32'h0, 32'h0, 1'b0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    q0.delete();
    q1.delete();
    stall0 = 1'b0;
    stall1 = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs("midreset_held");
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) tick(acc);
    single(2'b01, 32'h0000_0003, 32'h0000_0007, 1'b0);
    single(2'b00, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
